// File: rtl/reg_bank_load_ctrl.sv
// reg_bank_load_ctrl
// Fills a bank of NUM_REGS enable-gated registers from memory. On an accepted
// start it reads NUM_REGS consecutive words starting at base_addr. Each returned
// word is driven on reg_din and written with a one-cycle one-hot reg_en pulse.
// done pulses once when the bank is full.
//
// Optional feature: define REG_BANK_LOAD_CLEAR_EN to insert a one-cycle CLEAR
// state, which pulses reg_clr before the first read. Left undefined, reg_clr is
// tied to 0.
//
// Ports:
//   CLK, RST            clock; synchronous active-high reset
//   start, base_addr    load request and its starting word address
//   mem_rd, mem_addr    read request (held until mem_valid) and its address
//   mem_valid, mem_data read response
//   reg_din, reg_en     bank data bus and one-hot write enable
//   reg_clr             bank clear strobe (optional feature only)
//   busy, done          status: not IDLE / one-cycle load-complete pulse
module reg_bank_load_ctrl #(
    parameter int unsigned NUM_REGS = 25,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned IDX_W    = 5
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    output logic                mem_rd,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_valid,
    input  logic [DATA_W-1:0]   mem_data,
    output logic [DATA_W-1:0]   reg_din,
    output logic [NUM_REGS-1:0] reg_en,
    output logic                reg_clr,
    output logic                busy,
    output logic                done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

`ifdef REG_BANK_LOAD_CLEAR_EN
    typedef enum logic [2:0] {IDLE, REQ, WRITE, DONE, CLEAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, REQ, WRITE, DONE} state_t;
`endif

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [ADDR_W-1:0] addr_q;

    // Load sequencer; every output is registered here.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            idx      <= '0;
            addr_q   <= '0;
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            reg_din  <= '0;
            reg_en   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef REG_BANK_LOAD_CLEAR_EN
            reg_clr  <= 1'b0;
`endif
        end else begin
            // Strobes default low; each state raises only its own pulse.
            reg_en <= '0;
            done   <= 1'b0;
`ifdef REG_BANK_LOAD_CLEAR_EN
            reg_clr <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_q <= base_addr;
                        idx    <= '0;
                        busy   <= 1'b1;
`ifdef REG_BANK_LOAD_CLEAR_EN
                        reg_clr <= 1'b1;
                        state   <= CLEAR;
`else
                        mem_rd   <= 1'b1;
                        mem_addr <= base_addr;
                        state    <= REQ;
`endif
                    end
                end
`ifdef REG_BANK_LOAD_CLEAR_EN
                CLEAR: begin
                    mem_rd   <= 1'b1;
                    mem_addr <= addr_q;
                    state    <= REQ;
                end
`endif
                REQ: begin
                    // Request and address stay stable until the memory answers.
                    if (mem_valid) begin
                        reg_din <= mem_data;
                        mem_rd  <= 1'b0;
                        reg_en  <= NUM_REGS'(1) << idx;
                        state   <= WRITE;
                    end
                end
                WRITE: begin
                    if (idx == LAST_IDX) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx      <= idx + IDX_W'(1);
                        mem_rd   <= 1'b1;
                        // Address arithmetic wraps modulo 2^ADDR_W.
                        mem_addr <= addr_q + ADDR_W'(idx) + ADDR_W'(1);
                        state    <= REQ;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    mem_rd <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

`ifndef REG_BANK_LOAD_CLEAR_EN
    assign reg_clr = 1'b0;
`endif

endmodule

// File: tb/tb_reg_bank_load_ctrl.sv
// Directed bench for reg_bank_load_ctrl. A small memory model answers reads
// with 0xA5000000 + address after a configurable wait. Each cycle is checked
// against the expected address, write index and data.
module tb_reg_bank_load_ctrl;

    localparam int unsigned NREGS = 25;
`ifdef REG_BANK_LOAD_CLEAR_EN
    localparam int DONE_T = 2 * NREGS + 2;
`else
    localparam int DONE_T = 2 * NREGS + 1;
`endif

    logic        CLK;
    logic        RST;
    logic        start;
    logic [15:0] base_addr;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_data;
    logic [31:0] reg_din;
    logic [NREGS-1:0] reg_en;
    logic        reg_clr;
    logic        busy;
    logic        done;

    int vecs = 0;
    int errs = 0;

    reg_bank_load_ctrl dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .base_addr (base_addr),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_valid (mem_valid),
        .mem_data  (mem_data),
        .reg_din   (reg_din),
        .reg_en    (reg_en),
        .reg_clr   (reg_clr),
        .busy      (busy),
        .done      (done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vecs++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_mem_rd"},   32'(mem_rd),   32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_reg_din"},  reg_din,       32'd0);
        chk({tag, "_reg_en"},   32'(reg_en),   32'd0);
        chk({tag, "_reg_clr"},  32'(reg_clr),  32'd0);
        chk({tag, "_busy"},     32'(busy),     32'd0);
        chk({tag, "_done"},     32'(done),     32'd0);
    endtask

    // One full load. maxw: max wait cycles; hold: mem_valid stuck high;
    // spur: random mem_valid outside requests; pokes: start while busy;
    // abort_at: assert RST once this many registers are written (0 = never).
    task automatic run_load(input logic [15:0] base, input int maxw, input bit hold,
                            input bit spur, input bit pokes, input int abort_at);
        int          t;
        int          exp_idx;
        int          w;
        bit          fin;
        bit          prev_spur;
        logic [31:0] prev_din;
        logic [15:0] a;
        exp_idx   = 0;
        fin       = 1'b0;
        w         = int'($urandom_range(0, maxw));
        start     = 1'b1;
        base_addr = base;
        mem_valid = hold;
        mem_data  = $urandom;
        prev_spur = hold;
        prev_din  = reg_din;
        @(negedge CLK);
        t     = 1;
        start = 1'b0;
        while (!fin && t < 600) begin
            if (prev_spur) chk("din_hold", reg_din, prev_din);
`ifdef REG_BANK_LOAD_CLEAR_EN
            chk("reg_clr", 32'(reg_clr), 32'(t == 1));
            if (t == 1) chk("clr_no_rd", 32'(mem_rd), 32'd0);
`else
            chk("reg_clr", 32'(reg_clr), 32'd0);
`endif
            if (reg_en != '0) begin
                a = base + 16'(exp_idx);
                chk("reg_en", 32'(reg_en), 32'd1 << exp_idx);
                chk("reg_din", reg_din, 32'hA500_0000 + 32'(a));
                exp_idx++;
                if (abort_at > 0 && exp_idx == abort_at) begin
                    RST = 1'b1;
                    mem_valid = 1'b0;
                    @(negedge CLK);
                    chk_idle_zero("rst_mid");
                    RST = 1'b0;
                    return;
                end
            end
            if (mem_rd) begin
                a = base + 16'(exp_idx);
                chk("mem_addr", 32'(mem_addr), 32'(a));
            end
            if (done) begin
                if (maxw == 0) chk("done_cycle", 32'(t), 32'(DONE_T));
                chk("n_written", 32'(exp_idx), 32'(NREGS));
                fin = 1'b1;
            end else begin
                chk("busy", 32'(busy), 32'd1);
            end
            start = pokes && (t == 2 || done);
            if (mem_rd) begin
                if (hold || w == 0) begin
                    mem_valid = 1'b1;
                    mem_data  = 32'hA500_0000 + 32'(mem_addr);
                    w = int'($urandom_range(0, maxw));
                end else begin
                    mem_valid = 1'b0;
                    w--;
                end
                prev_spur = 1'b0;
            end else begin
                mem_valid = hold ? 1'b1 : (spur ? 1'($urandom_range(0, 1)) : 1'b0);
                mem_data  = $urandom;
                prev_spur = mem_valid;
            end
            prev_din = reg_din;
            @(negedge CLK);
            t++;
        end
        if (!fin) chk("done_timeout", 32'd0, 32'd1);
        if (prev_spur) chk("din_hold_end", reg_din, prev_din);
        chk("busy_fall", 32'(busy), 32'd0);
        chk("done_once", 32'(done), 32'd0);
        chk("no_restart", 32'(mem_rd), 32'd0);
        start     = 1'b0;
        mem_valid = 1'b0;
    endtask

    initial begin
        RST       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        mem_valid = 1'b0;
        mem_data  = '0;
        repeat (3) @(negedge CLK);
        chk_idle_zero("reset");
        RST = 1'b0;
        @(negedge CLK);

        run_load(16'h0100, 0, 1'b0, 1'b0, 1'b0, 0);   // basic load
        run_load(16'h2000, 0, 1'b1, 1'b0, 1'b0, 0);   // mem_valid stuck high
        run_load(16'h0340, 7, 1'b0, 1'b0, 1'b0, 0);   // wait states
        run_load(16'hFFF0, 3, 1'b0, 1'b0, 1'b0, 0);   // address wrap
        run_load(16'h0500, 2, 1'b0, 1'b1, 1'b1, 0);   // start pokes, spurious valid
        run_load(16'h0600, 1, 1'b0, 1'b0, 1'b0, 11);  // reset after register 10

        // Idle after reset: spurious valid must not write or latch.
        for (int i = 0; i < 3; i++) begin
            mem_valid = 1'b1;
            mem_data  = $urandom;
            @(negedge CLK);
            chk("idle_reg_en", 32'(reg_en), 32'd0);
            chk("idle_reg_din", reg_din, 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
        end
        mem_valid = 1'b0;

        run_load(16'h0700, 0, 1'b0, 1'b0, 1'b0, 0);   // reload from index 0

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/reg_bank_load_ctrl.md
Name: reg_bank_load_ctrl

Overview:
Sequencer that fills a bank of NUM_REGS rising-edge, enable-gated 32-bit registers (filter/window registers of the convolution datapath) from memory. On a start pulse it issues one memory read per register from consecutive addresses and routes each returned word to the matching register with a one-cycle one-hot enable. It signals done when the whole bank is loaded. It sits between the memory interface and the register bank and is the only writer of the bank during a load.

Parameters:
NUM_REGS, 25, number of registers in the bank (5x5 window); legal range 2..32
DATA_W, 32, register/memory data width
ADDR_W, 16, memory address width
IDX_W, 5, register index width; must satisfy 2^IDX_W >= NUM_REGS

Ports:
CLK  in  1  clock; all logic rising-edge
RST  in  1  synchronous active-high reset
start  in  1  begin load; sampled only in IDLE
base_addr  in  ADDR_W  address of register 0's word; captured on accepted start
mem_rd  out  1  read request; held until mem_valid
mem_addr  out  ADDR_W  read address
mem_valid  in  1  read data valid; completes the outstanding request
mem_data  in  DATA_W  read data
reg_din  out  DATA_W  data bus to all bank registers (registered)
reg_en  out  NUM_REGS  one-hot write enable, bit i = register i
reg_clr  out  1  bank clear strobe (only with optional feature)
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last register write

Behaviour:
- Reset (RST=1 at a rising edge): state=IDLE; idx=0; mem_rd=0, mem_addr=0, reg_din=0, reg_en=0, reg_clr=0, busy=0, done=0. Reset mid-load aborts immediately with no further reg_en. Bank contents are left as-is.
- All outputs are registered.
- States: IDLE, REQ, WRITE, DONE (plus CLEAR with the optional feature).
- IDLE: when start=1, capture base_addr into addr_q, set idx=0 and go to REQ. The same edge drives mem_rd=1 and mem_addr=base_addr. If start=0, stay in IDLE.
- REQ: mem_rd=1, mem_addr=addr_q+idx, with modulo 2^ADDR_W wrap.
  - If mem_valid=1, latch mem_data into reg_din, drop mem_rd and go to WRITE.
  - mem_valid may arrive in the first REQ cycle. An arbitrary number of wait cycles is allowed.
- WRITE: reg_en has exactly bit idx set for this one cycle, and reg_din holds the latched word.
  - If idx==NUM_REGS-1, go to DONE.
  - Otherwise idx+=1 and go to REQ.
- DONE: done=1 for exactly one cycle, then IDLE. busy drops on entering IDLE.
- Throughput: minimum 2 cycles per register (REQ with immediate valid, then WRITE). Full load takes at least 2*NUM_REGS+1 cycles from start to done.
- start while busy (REQ/WRITE/DONE) is ignored; it is not queued.
- mem_valid outside REQ is ignored; no data is latched and no enable is produced.
- reg_en is never multi-hot and is all-zero outside WRITE.
- Bits of reg_en above NUM_REGS-1 do not exist; idx never exceeds NUM_REGS-1.

Optional Feature:
Macro REG_BANK_LOAD_CLEAR_EN.
- Defined: an accepted start goes IDLE->CLEAR instead of REQ. CLEAR lasts one cycle with reg_clr=1, busy=1, mem_rd=0, reg_en=0, then goes to REQ. The load takes one extra cycle.
- Undefined: the CLEAR state does not exist, reg_clr is tied to 0, and timing is as above.

Test Plan:
- Basic load: NUM_REGS=25, base_addr=0x0100, memory returns mem_valid one cycle after mem_rd with data=0xA5000000+addr. Required response:
  - mem_addr runs 0x0100..0x0118;
  - register i receives 0xA5000100+i via a single reg_en pulse;
  - done pulses once, 51 cycles after start;
  - busy falls the cycle after done.
- Same-cycle valid: mem_valid held at 1 permanently -> exactly 2 cycles per register, no skipped or duplicated index, done exactly 51 cycles after start.
- Wait states: random 0-7 cycle mem_valid delay -> mem_rd and mem_addr stay stable until valid. reg_en order is 0..24 with no gaps, and each data word matches its address.
- Address wrap: base_addr=0xFFF0 -> addresses 0xFFF0..0xFFFF then 0x0000..0x0008, with data mapped to indices 0..24.
- Protocol corners: start pulsed during REQ and DONE -> ignored, exactly one done. Spurious mem_valid in IDLE/WRITE/DONE -> no reg_en and reg_din unchanged.
- Reset mid-load: RST=1 after register 10 is written -> next cycle all outputs 0, state IDLE, no further reg_en. A new start then reloads from index 0. With REG_BANK_LOAD_CLEAR_EN defined, reg_clr pulses for exactly one cycle before the first mem_rd.
